// File: rtl/la_capture_core.sv
// Logic-analyzer capture core: synchronized channel sampling into a circular buffer
// with pre/post-trigger windows, edge/immediate trigger and logical-index readback.
module la_capture_core #(
    parameter int unsigned CHANNEL_COUNT = 10,
    parameter int unsigned DEPTH         = 1024,
    parameter int unsigned PRE_TRIGGER   = 256,
    parameter int unsigned DIV_WIDTH     = 32,
    localparam int unsigned CW = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CHANNEL_COUNT-1:0] chan_in,
    input  logic [DIV_WIDTH-1:0]     sample_div,
    input  logic [CW-1:0]            trig_chan,
    input  logic [1:0]               trig_mode,
    input  logic                     auto_rearm,
    input  logic                     arm,
    input  logic                     abort,
    input  logic [AW-1:0]            rd_addr,
    output logic [CHANNEL_COUNT-1:0] rd_data,
    output logic [2:0]               state,
    output logic                     done,
    output logic                     trig_seen
);

    localparam int unsigned POST_LEN = DEPTH - PRE_TRIGGER - 1;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StPre  = 3'd1,
        StWait = 3'd2,
        StPost = 3'd3,
        StDone = 3'd4
    } state_e;

    state_e                   state_q, state_d;
    logic [CHANNEL_COUNT-1:0] sync1_q, sync2_q;
    logic [DIV_WIDTH-1:0]     div_q, div_d;
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [AW:0]              cnt_q, cnt_d;
    logic [AW-1:0]            trig_addr_q, trig_addr_d;
    logic                     trig_seen_q, trig_seen_d;
    logic [CHANNEL_COUNT-1:0] last_q, last_d;
    logic                     last_valid_q, last_valid_d;
    logic [CHANNEL_COUNT-1:0] rd_data_q;
    logic [CHANNEL_COUNT-1:0] mem_q [DEPTH];

    logic        strobe, wr_en, cur_bit, prev_bit, chan_ok, edge_hit, trig_hit;
    logic [AW:0] cnt_inc;
    logic [AW-1:0] rd_phys;

    // >= keeps the divider from running through its full range if sample_div shrinks mid-count
    assign strobe  = (div_q >= sample_div);
    assign div_d   = strobe ? '0 : div_q + 1'b1;
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        cur_bit  = 1'b0;
        prev_bit = 1'b0;
        chan_ok  = 1'b0;
        for (int i = 0; i < int'(CHANNEL_COUNT); i++) begin
            if (trig_chan == CW'(i)) begin
                cur_bit  = sync2_q[i];
                prev_bit = last_q[i];
                chan_ok  = 1'b1;
            end
        end
        unique case (trig_mode)
            2'd0:    edge_hit = ~prev_bit & cur_bit;
            2'd1:    edge_hit = prev_bit & ~cur_bit;
            default: edge_hit = prev_bit ^ cur_bit;
        endcase
        // Edge modes need a real previous sample from this capture
        trig_hit = (trig_mode == 2'd3) | (chan_ok & last_valid_q & edge_hit);
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        cnt_d        = cnt_q;
        trig_addr_d  = trig_addr_q;
        trig_seen_d  = trig_seen_q;
        wr_en        = 1'b0;
        unique case (state_q)
            StIdle: if (arm) state_d = StPre;
            StPre: begin
                if (PRE_TRIGGER == 0) begin
                    state_d = StWait;
                end else if (strobe) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    cnt_d    = cnt_inc;
                    if (cnt_inc == (AW+1)'(PRE_TRIGGER)) begin
                        state_d = StWait;
                        cnt_d   = '0;
                    end
                end
            end
            StWait: begin
                if (strobe) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (trig_hit) begin
                        trig_addr_d = wr_ptr_q;
                        trig_seen_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = (POST_LEN == 0) ? StDone : StPost;
                    end
                end
            end
            StPost: begin
                if (strobe) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    cnt_d    = cnt_inc;
                    if (cnt_inc == (AW+1)'(POST_LEN)) state_d = StDone;
                end
            end
            StDone: if (arm || auto_rearm) state_d = StPre;
            default: state_d = StIdle;
        endcase
        if (state_d == StPre && (state_q == StIdle || state_q == StDone)) begin
            wr_ptr_d    = '0;
            cnt_d       = '0;
            trig_seen_d = 1'b0;
        end
        if (abort) begin
            state_d     = StIdle;
            trig_seen_d = 1'b0;
            wr_en       = 1'b0;
        end
    end

    always_comb begin
        last_d       = last_q;
        last_valid_d = last_valid_q;
        if (state_d == StPre && state_q != StPre) last_valid_d = 1'b0;
        if (wr_en) begin
            last_d       = sync2_q;
            last_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            sync1_q      <= '0;
            sync2_q      <= '0;
            div_q        <= '0;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
            trig_addr_q  <= '0;
            trig_seen_q  <= 1'b0;
            last_q       <= '0;
            last_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= chan_in;
            sync2_q      <= sync1_q;
            div_q        <= div_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            trig_addr_q  <= trig_addr_d;
            trig_seen_q  <= trig_seen_d;
            last_q       <= last_d;
            last_valid_q <= last_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= sync2_q;
    end

    assign rd_phys = trig_addr_q - AW'(PRE_TRIGGER) + rd_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_data_q <= '0;
        else       rd_data_q <= mem_q[rd_phys];
    end

    assign rd_data   = rd_data_q;
    assign state     = state_q;
    assign done      = (state_q == StDone);
    assign trig_seen = trig_seen_q;

endmodule

// File: tb/tb_la_capture_core.sv
// Directed bench for la_capture_core: a default instance plus a small PRE_TRIGGER=0 instance.
module tb_la_capture_core;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  chan_in;
    logic [31:0] sample_div = '0;
    logic [3:0]  trig_chan = 4'd2;
    logic [1:0]  trig_mode = 2'd0;
    logic        auto_rearm = 1'b0, arm = 1'b0, abort = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic [9:0]  rd_data;
    logic [2:0]  state;
    logic        done, trig_seen;

    logic [9:0]  chan0 = 10'h2A5;
    logic        arm0 = 1'b0;
    logic [3:0]  rd_addr0 = '0;
    logic [9:0]  rd_data0;
    logic [2:0]  state0;
    logic        done0, ts0;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    int unsigned cnt = 0;
    int unsigned rise_at = 32'hFFFF_FFFF;
    bit          cnt_en = 1'b0;
    logic [9:0]  man_val = 10'h000;

    always #5 clk = ~clk;

    la_capture_core u_dut (
        .clk(clk), .reset(reset), .chan_in(chan_in), .sample_div(sample_div),
        .trig_chan(trig_chan), .trig_mode(trig_mode), .auto_rearm(auto_rearm),
        .arm(arm), .abort(abort), .rd_addr(rd_addr), .rd_data(rd_data),
        .state(state), .done(done), .trig_seen(trig_seen)
    );

    la_capture_core #(.CHANNEL_COUNT(10), .DEPTH(16), .PRE_TRIGGER(0), .DIV_WIDTH(32)) u_dut0 (
        .clk(clk), .reset(reset), .chan_in(chan0), .sample_div(32'd7),
        .trig_chan(4'd0), .trig_mode(2'd2), .auto_rearm(1'b0),
        .arm(arm0), .abort(1'b0), .rd_addr(rd_addr0), .rd_data(rd_data0),
        .state(state0), .done(done0), .trig_seen(ts0)
    );

    // Channel driver: counter pattern with bit2 rising at cnt == rise_at, or a manual value
    initial begin
        chan_in = 10'h000;
        forever begin
            @(posedge clk);
            #1;
            if (cnt_en) begin
                cnt++;
                chan_in = {cnt[6:0], (cnt >= rise_at), 2'b01};
            end else begin
                chan_in = man_val;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string tag,
                              output int n);
        n = 0;
        while (state !== st && n < budget) begin
            tick();
            n++;
        end
        check(tag, {29'd0, state}, {29'd0, st});
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        int n;
        int unsigned v;
        logic [6:0] c;
        logic [31:0] e;

        // Reset
        #2 reset = 1'b1;
        repeat (3) tick();
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_trig_seen", {31'd0, trig_seen}, 32'd0);
        check("rst_rd_data", {22'd0, rd_data}, 32'd0);
        reset = 1'b0;
        repeat (3) tick();

        // Rising trigger on channel 2, strobe every cycle
        cnt_en = 1'b1;
        sample_div = 0; trig_mode = 2'd0; trig_chan = 4'd2;
        pulse_arm();
        check("a_arm_pre", {29'd0, state}, 32'd1);
        wait_state(3'd2, 400, "a_pre_to_wait", n);
        check("a_pre_len", (n >= 250 && n <= 258) ? 32'd1 : 32'd0, 32'd1);
        rise_at = cnt + 150;
        wait_state(3'd4, 2000, "a_done_state", n);
        check("a_done", {31'd0, done}, 32'd1);
        check("a_trig_seen", {31'd0, trig_seen}, 32'd1);
        for (int i = 0; i < 1024; i++) begin
            rd_addr = 10'(i);
            v = rise_at + 32'(i) - 32'd256;
            c = v[6:0];
            exp_q.push_back({22'd0, c, (i >= 256), 2'b01});
            tick();
            e = exp_q.pop_front();
            check($sformatf("a_rd[%0d]", i), {22'd0, rd_data}, e);
        end
        cnt_en = 1'b0;

        // Immediate trigger, strobe every 4 cycles, re-armed from DONE
        sample_div = 3; trig_mode = 2'd3;
        pulse_arm();
        check("b_arm_from_done", {29'd0, state}, 32'd1);
        wait_state(3'd4, 5000, "b_done_state", n);
        check("b_period", (n + 1 >= 4090 && n + 1 <= 4102) ? 32'd1 : 32'd0, 32'd1);
        check("b_trig_seen", {31'd0, trig_seen}, 32'd1);

        // Falling trigger on a channel held high never fires
        sample_div = 0; trig_mode = 2'd1; trig_chan = 4'd0; man_val = 10'h001;
        repeat (5) tick();
        pulse_arm();
        wait_state(3'd2, 400, "c_wait", n);
        repeat (600) tick();
        check("c_stuck_wait", {29'd0, state}, 32'd2);
        check("c_no_trig", {31'd0, trig_seen}, 32'd0);
        pulse_abort();
        check("c_abort_idle", {29'd0, state}, 32'd0);
        check("c_abort_ts", {31'd0, trig_seen}, 32'd0);

        // Out-of-range trigger channel with either-edge mode
        trig_chan = 4'd12; trig_mode = 2'd2;
        pulse_arm();
        wait_state(3'd2, 400, "c_oor_wait", n);
        for (int i = 0; i < 50; i++) begin
            man_val = (i % 2 == 0) ? 10'h3FF : 10'h000;
            tick();
        end
        check("c_oor_stuck", {29'd0, state}, 32'd2);
        pulse_abort();
        pulse_arm();
        check("c_rearm_pre", {29'd0, state}, 32'd1);
        arm = 1'b1; abort = 1'b1;
        tick();
        arm = 1'b0; abort = 1'b0;
        check("c_arm_abort", {29'd0, state}, 32'd0);

        // Auto re-arm and arm ignored in POST
        auto_rearm = 1'b1; trig_mode = 2'd3; trig_chan = 4'd0;
        pulse_arm();
        wait_state(3'd3, 400, "d_post", n);
        pulse_arm();
        check("d_arm_in_post", {29'd0, state}, 32'd3);
        wait_state(3'd4, 1000, "d_done_state", n);
        check("d_done_hi", {31'd0, done}, 32'd1);
        tick();
        check("d_rearm_pre", {29'd0, state}, 32'd1);
        check("d_done_lo", {31'd0, done}, 32'd0);
        auto_rearm = 1'b0;
        pulse_abort();

        // PRE_TRIGGER=0 instance: no prev on the first WAIT strobe
        arm0 = 1'b1;
        tick();
        arm0 = 1'b0;
        check("e_pre", {29'd0, state0}, 32'd1);
        tick();
        check("e_wait", {29'd0, state0}, 32'd2);
        repeat (9) tick();
        check("e_first_no_trig", {29'd0, state0}, 32'd2);
        check("e_first_ts", {31'd0, ts0}, 32'd0);
        chan0 = 10'h2A4;
        n = 0;
        while (state0 === 3'd2 && n < 30) begin
            tick();
            n++;
        end
        check("e_second_trig", {31'd0, ts0}, 32'd1);
        n = 0;
        while (done0 !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check("e_done", {31'd0, done0}, 32'd1);
        for (int i = 0; i < 16; i += 15) begin
            rd_addr0 = 4'(i);
            exp_q.push_back(32'h2A4);
            tick();
            e = exp_q.pop_front();
            check($sformatf("e_rd[%0d]", i), {22'd0, rd_data0}, e);
        end

        // Asynchronous reset during POST
        sample_div = 3; trig_mode = 2'd3;
        pulse_arm();
        wait_state(3'd3, 2000, "f_post", n);
        repeat (5) tick();
        #2 reset = 1'b1;
        #1;
        check("f_rst_state", {29'd0, state}, 32'd0);
        check("f_rst_done", {31'd0, done}, 32'd0);
        check("f_rst_ts", {31'd0, trig_seen}, 32'd0);
        check("f_rst_rd", {22'd0, rd_data}, 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (20) tick();
        check("f_hold_idle", {29'd0, state}, 32'd0);
        pulse_arm();
        check("f_arm_pre", {29'd0, state}, 32'd1);
        pulse_abort();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
